// File: rtl/defec_descr_s2p_1x8_if.sv
// Serial-in / byte-out bundle for the DeFEC descrambler and serial-to-parallel stage.
// The master side drives the serial bit stream and observes the byte stream.
// The slave side (the descrambler) consumes bits and produces bytes.
interface defec_descr_s2p_1x8_if;
  logic       idat;
  logic       ival;
  logic       isop;
  logic [7:0] odat;
  logic       oval;
  logic       osop;
  logic       oeop;
  logic       oerr;

  modport master (
    output idat, ival, isop,
    input  odat, oval, osop, oeop, oerr
  );

  modport slave (
    input  idat, ival, isop,
    output odat, oval, osop, oeop, oerr
  );
endinterface

// File: rtl/defec_descr_s2p_1x8.sv
// DeFEC descrambler + 1-to-8 serial-to-parallel packer.
// Takes the never-stalling serial stream (bit, valid, start-of-packet), removes additive
// PRBS scrambling, packs bits MSB-first into bytes and flags the first and last byte of
// every FRAME_BYTES-byte frame. A start-of-packet seen mid-frame restarts framing and sets
// the sticky error flag.
// Build option: define DEFEC_DESCR_EN to build the descrambler; without it the received
// bits pass straight into the packer (framing, flags and latency are identical).
module defec_descr_s2p_1x8 #(
  parameter int unsigned FRAME_BYTES = 188
`ifdef DEFEC_DESCR_EN
  ,
  parameter int unsigned LFSR_W = 15,
  parameter int unsigned TAP_A  = 14,
  parameter int unsigned TAP_B  = 13,
  parameter logic [LFSR_W-1:0] SEED = 15'b100101010000000
`endif
) (
  input  logic                 iclk,
  input  logic                 irst,
  defec_descr_s2p_1x8_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned BCW = $clog2(FRAME_BYTES);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [6:0]     sh_q, sh_d;
  logic [7:0]     odat_q, odat_d;
  logic           oval_q, oval_d;
  logic           osop_q, osop_d;
  logic           oeop_q, oeop_d;
  logic           oerr_q, oerr_d;
  logic           dbit_s;

`ifdef DEFEC_DESCR_EN
  // SEED is written in the customary stage-1-first order (leftmost character is the stage
  // that receives the feedback), so the register is loaded with it bit-reversed. This makes
  // lfsr[TAP_A]/lfsr[TAP_B] the last two stages and yields 0x03,0xF6,0x08,... for zero data.
  function automatic logic [LFSR_W-1:0] seed_load(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    r = {LFSR_W{1'b0}};
    for (int i = 0; i < int'(LFSR_W); i++) begin
      r[i] = s[int'(LFSR_W) - 1 - i];
    end
    return r;
  endfunction

  localparam logic [LFSR_W-1:0] SEED_LD = seed_load(SEED);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] lfsr_base_s;
  logic [LFSR_W-1:0] lfsr_step_s;
  logic              fb_s;

  // Keystream bit for the current input; a frame-start bit steps from the reloaded seed.
  always_comb begin
    if (bus.isop) begin
      lfsr_base_s = SEED_LD;
    end else begin
      lfsr_base_s = lfsr_q;
    end
    fb_s        = lfsr_base_s[TAP_A] ^ lfsr_base_s[TAP_B];
    dbit_s      = bus.idat ^ fb_s;
    lfsr_step_s = {lfsr_base_s[LFSR_W-2:0], fb_s};
  end

  // LFSR advances only on bits that belong to a frame (frame-start or RUN-state bits).
  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.ival && (bus.isop || (state_q == ST_RUN))) begin
      lfsr_d = lfsr_step_s;
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      lfsr_q <= SEED_LD;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  // Descrambling not built: the received bit is already the payload bit.
  always_comb begin
    dbit_s = bus.idat;
  end
`endif

  // Framing FSM, bit packer, byte counter and output strobes.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sh_d       = sh_q;
    odat_d     = odat_q;
    oval_d     = 1'b0;
    osop_d     = 1'b0;
    oeop_d     = 1'b0;
    oerr_d     = oerr_q;

    if (bus.ival) begin
      if (bus.isop) begin
        // Frame start: any partial byte is dropped and this bit becomes bit 0.
        if (state_q == ST_RUN) begin
          oerr_d = 1'b1;
        end else begin
          oerr_d = oerr_q;
        end
        state_d    = ST_RUN;
        bit_cnt_d  = 3'd1;
        byte_cnt_d = {BCW{1'b0}};
        sh_d       = {6'b000000, dbit_s};
      end else begin
        case (state_q)
          ST_RUN: begin
            sh_d      = {sh_q[5:0], dbit_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              odat_d = {sh_q, dbit_s};
              oval_d = 1'b1;
              osop_d = (byte_cnt_q == {BCW{1'b0}});
              oeop_d = (byte_cnt_q == LAST_BYTE);
              if (byte_cnt_q == LAST_BYTE) begin
                byte_cnt_d = {BCW{1'b0}};
                state_d    = ST_IDLE;
              end else begin
                byte_cnt_d = byte_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
                state_d    = ST_RUN;
              end
            end else begin
              odat_d = odat_q;
            end
          end
          ST_IDLE: begin
            // Bits outside a frame are discarded.
            state_d = ST_IDLE;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= {BCW{1'b0}};
      sh_q       <= 7'd0;
      odat_q     <= 8'd0;
      oval_q     <= 1'b0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sh_q       <= sh_d;
      odat_q     <= odat_d;
      oval_q     <= oval_d;
      osop_q     <= osop_d;
      oeop_q     <= oeop_d;
      oerr_q     <= oerr_d;
    end
  end

  assign bus.odat = odat_q;
  assign bus.oval = oval_q;
  assign bus.osop = osop_q;
  assign bus.oeop = oeop_q;
  assign bus.oerr = oerr_q;

endmodule

// File: tb/tb_defec_descr_s2p_1x8.sv
// Randomized self-checking bench for defec_descr_s2p_1x8.
// Reference model: frame bit index arithmetic plus a stage-array PRBS (stage 1 first),
// producing expected bytes/flags one clock after each 8th frame bit.
module tb_defec_descr_s2p_1x8;
  localparam int FB = 188;
  localparam int NB = FB * 8;
  localparam logic [1:15] DVB_INIT = 15'b100101010000000;

  logic clk;
  logic rst_n;
  defec_descr_s2p_1x8_if bus ();

  defec_descr_s2p_1x8 dut (
    .iclk(clk),
    .irst(rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  logic [1:15] m_st;
  bit          m_in_frame;
  bit          m_err;
  int          m_bits;
  int          m_acc;
  // recording of DUT bytes
  logic [7:0]  rec[$];
  logic [7:0]  rec_a[$];
  int          sop_cnt;
  int          eop_cnt;
  bit          data_arr[NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:15] adv(input logic [1:15] s);
    return {s[14] ^ s[15], s[1:14]};
  endfunction

  // One clock of stimulus; starts and ends at a negedge, checks outputs one edge later.
  task automatic step(input bit d, input bit v, input bit s);
    bit         db;
    bit         e_val;
    logic [7:0] e_dat;
    bit         e_sop;
    bit         e_eop;
    int         nb;
    e_val = 1'b0; e_dat = 8'd0; e_sop = 1'b0; e_eop = 1'b0;
    bus.idat = d; bus.ival = v; bus.isop = s;
    if (v) begin
      if (s) begin
        if (m_in_frame) m_err = 1'b1;
        m_in_frame = 1'b1;
        m_bits = 0;
        m_acc = 0;
        m_st = DVB_INIT;
      end
      if (m_in_frame) begin
`ifdef DEFEC_DESCR_EN
        db = d ^ m_st[14] ^ m_st[15];
`else
        db = d;
`endif
        m_st = adv(m_st);
        m_acc = ((m_acc << 1) | int'(db)) & 255;
        m_bits++;
        if (m_bits % 8 == 0) begin
          nb    = m_bits / 8 - 1;
          e_val = 1'b1;
          e_dat = m_acc[7:0];
          e_sop = (nb == 0);
          e_eop = (nb == FB - 1);
          if (e_eop) m_in_frame = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("oval", {31'd0, bus.oval}, {31'd0, e_val});
    if (bus.oval) begin
      rec.push_back(bus.odat);
      if (bus.osop) sop_cnt++;
      if (bus.oeop) eop_cnt++;
    end
    if (e_val) begin
      chk("odat", {24'd0, bus.odat}, {24'd0, e_dat});
      chk("osop", {31'd0, bus.osop}, {31'd0, e_sop});
      chk("oeop", {31'd0, bus.oeop}, {31'd0, e_eop});
    end else begin
      chk("flags_idle", {30'd0, bus.osop, bus.oeop}, 32'd0);
    end
    chk("oerr", {31'd0, bus.oerr}, {31'd0, m_err});
  endtask

  // Fill data_arr: 0 zeros, 1 random, 2 keystream^0xA5 (raw 0xA5 without descrambler).
  task automatic fill(input int mode);
    logic [1:15] g;
    logic [7:0]  pat;
    bit          k;
    g = DVB_INIT;
    pat = 8'hA5;
    for (int i = 0; i < NB; i++) begin
`ifdef DEFEC_DESCR_EN
      k = g[14] ^ g[15];
`else
      k = 1'b0;
`endif
      g = adv(g);
      case (mode)
        0:       data_arr[i] = 1'b0;
        1:       data_arr[i] = bit'($urandom_range(0, 1));
        default: data_arr[i] = pat[7 - (i % 8)] ^ k;
      endcase
    end
  endtask

  // Send n bits of data_arr; optional isop on bit 0; optional random idle gaps (~50% duty).
  task automatic send(input int n, input bit sop0, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) step(bit'($urandom_range(0, 1)), 1'b0, bit'($urandom_range(0, 1)));
      end
      step(data_arr[i], 1'b1, sop0 && (i == 0));
    end
  endtask

  // Asynchronous reset pulse starting at a negedge; outputs must clear at once.
  task automatic do_reset();
    bus.ival = 1'b0; bus.isop = 1'b0; bus.idat = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_oval", {31'd0, bus.oval}, 32'd0);
    chk("rst_odat", {24'd0, bus.odat}, 32'd0);
    chk("rst_osop", {31'd0, bus.osop}, 32'd0);
    chk("rst_oeop", {31'd0, bus.oeop}, 32'd0);
    chk("rst_oerr", {31'd0, bus.oerr}, 32'd0);
    m_in_frame = 1'b0;
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int diffs;

  initial begin
    rst_n = 1'b0;
    bus.idat = 1'b0; bus.ival = 1'b0; bus.isop = 1'b0;
    m_st = DVB_INIT; m_in_frame = 1'b0; m_err = 1'b0; m_bits = 0; m_acc = 0;
    sop_cnt = 0; eop_cnt = 0;
    repeat (3) @(negedge clk);
    do_reset();

    // bits with no preceding isop produce nothing
    fill(1);
    send(40, 1'b0, 1'b0);
    chk("no_sop_bytes", rec.size(), 32'd0);

    // all-zero frame
    fill(0);
    rec.delete(); sop_cnt = 0; eop_cnt = 0;
    send(NB, 1'b1, 1'b0);
    chk("zero_nbytes", rec.size(), FB);
    chk("zero_sop_cnt", sop_cnt, 32'd1);
    chk("zero_eop_cnt", eop_cnt, 32'd1);
`ifdef DEFEC_DESCR_EN
    chk("prbs_b0", {24'd0, rec[0]}, 32'h03);
    chk("prbs_b1", {24'd0, rec[1]}, 32'hF6);
    chk("prbs_b2", {24'd0, rec[2]}, 32'h08);
`endif

    // keystream^0xA5 payload descrambles to constant 0xA5 (raw 0xA5 without descrambler)
    fill(2);
    rec.delete();
    send(NB, 1'b1, 1'b0);
    diffs = 0;
    foreach (rec[i]) if (rec[i] != 8'hA5) diffs++;
    chk("a5_nbytes", rec.size(), FB);
    chk("a5_diffs", diffs, 32'd0);

    // gapless vs gapped transmission of the same random frame
    fill(1);
    rec.delete();
    send(NB, 1'b1, 1'b0);
    rec_a = rec;
    rec.delete();
    send(NB, 1'b1, 1'b1);
    diffs = 0;
    foreach (rec[i]) if (i < rec_a.size() && rec[i] != rec_a[i]) diffs++;
    chk("gap_nbytes", rec.size(), rec_a.size());
    chk("gap_diffs", diffs, 32'd0);

    // restart after 3 bits of byte 5, then a full zero frame
    fill(0);
    send(5 * 8 + 3, 1'b1, 1'b0);
    rec.delete(); sop_cnt = 0;
    send(NB, 1'b1, 1'b0);
    chk("restart_err", {31'd0, bus.oerr}, 32'd1);
    chk("restart_nbytes", rec.size(), FB);
    chk("restart_sop_cnt", sop_cnt, 32'd1);
`ifdef DEFEC_DESCR_EN
    chk("restart_b0", {24'd0, rec[0]}, 32'h03);
`endif

    // isop on the bit that would complete the last byte, then a full random frame
    fill(1);
    rec.delete();
    send(NB - 1, 1'b1, 1'b0);
    chk("last_nbytes", rec.size(), FB - 1);
    send(NB, 1'b1, 1'b1);

    // reset during byte 10, stray bits, then a clean random frame
    send(10 * 8 + 4, 1'b1, 1'b0);
    do_reset();
    send(12, 1'b0, 1'b0);
    rec.delete();
    send(NB, 1'b1, 1'b0);
    chk("post_rst_nbytes", rec.size(), FB);
    chk("post_rst_err", {31'd0, bus.oerr}, 32'd0);
`ifndef DEFEC_DESCR_EN
    diffs = 0;
    for (int b = 0; b < FB && b < rec.size(); b++) begin
      logic [7:0] raw;
      for (int j = 0; j < 8; j++) raw[7 - j] = data_arr[b * 8 + j];
      if (rec[b] != raw) diffs++;
    end
    chk("raw_diffs", diffs, 32'd0);
`endif

    repeat (3) step(1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
